gpio_irq_ctrl: RTL and testbench

Register-mapped controller for the board GPIO (switches in, LEDs out) on the CNN SoC processor bus. Per-bit functions:
- synchronises and debounces switch inputs
- latches rising-edge events into a sticky interrupt status register
- applies a mask and drives a single level interrupt to the processor
- holds the LED output register

---
 rtl/gpio_irq_ctrl_if.sv | 14 +
 rtl/gpio_irq_ctrl.sv | 116 +++++++++++
 tb/tb_gpio_irq_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_irq_ctrl_if.sv
// Processor bus port of the GPIO interrupt controller: single-cycle
// read/write strobes, 2-bit register select, registered read data.
interface gpio_irq_ctrl_if #(
  parameter int N_GPIO = 4
);
  logic              wr_en;
  logic              rd_en;
  logic [1:0]        addr;
  logic [N_GPIO-1:0] wdata;
  logic [N_GPIO-1:0] rdata;

  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/gpio_irq_ctrl.sv
// GPIO controller: synchronises and debounces switches, latches rising
// edges into a sticky W1C status register, masks them into one level
// interrupt, and holds the LED output register.
module gpio_irq_ctrl #(
  parameter int N_GPIO          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_GPIO-1:0] sw,
  output logic [N_GPIO-1:0] led,
  gpio_irq_ctrl_if.slave    bus,
  output logic              irq
);

  typedef enum logic [1:0] {
    ADDR_SW_IN      = 2'd0,
    ADDR_LED_OUT    = 2'd1,
    ADDR_IRQ_MASK   = 2'd2,
    ADDR_IRQ_STATUS = 2'd3
  } reg_addr_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  reg_addr_e         sel;
  logic [N_GPIO-1:0] sync1;
  logic [N_GPIO-1:0] sw_sync;
  logic [N_GPIO-1:0] sw_stable;
  logic [CNT_W-1:0]  cnt [N_GPIO];
  logic [N_GPIO-1:0] mask;
  logic [N_GPIO-1:0] status;
  logic [N_GPIO-1:0] status_next;
  logic [N_GPIO-1:0] rise;
  logic [N_GPIO-1:0] clr;
  logic [N_GPIO-1:0] rd_mux;

  assign sel = reg_addr_e'(bus.addr);

  // Two-flop synchroniser for the asynchronous switch inputs.
  // NOTE: every sequential block uses non-blocking (<=) assignments so all
  // flops sample pre-edge values; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sw_sync <= '0;
    end else begin
      sync1   <= sw;
      sw_sync <= sync1;
    end
  end

  // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive
  // differing samples; any matching sample restarts the count.
  // NOTE: the counter array is ordinary flops and is cleared in the reset
  // branch, so a mid-operation reset also discards in-flight counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_stable <= '0;
      for (int i = 0; i < N_GPIO; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_GPIO; i++) begin
        if (sw_sync[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          sw_stable[i] <= sw_sync[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge events, W1C clear vector and next status value.
  // NOTE: each output gets a default before any conditional assignment so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rise = '0;
    clr  = '0;
    for (int i = 0; i < N_GPIO; i++)
      rise[i] = !sw_stable[i] && sw_sync[i] && (cnt[i] == CNT_MAX);
    if (bus.wr_en && sel == ADDR_IRQ_STATUS) clr = bus.wdata;
    status_next = (status & ~clr) | rise;
  end

  // Read mux; returns pre-write register contents.
  always_comb begin
    rd_mux = '0;
    case (sel)
      ADDR_SW_IN:      rd_mux = sw_stable;
      ADDR_LED_OUT:    rd_mux = led;
      ADDR_IRQ_MASK:   rd_mux = mask;
      ADDR_IRQ_STATUS: rd_mux = status;
      default:         rd_mux = '0;
    endcase
  end

  // Bus-visible registers: LED, mask, sticky status, interrupt and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led       <= '0;
      mask      <= '0;
      status    <= '0;
      irq       <= 1'b0;
      bus.rdata <= '0;
    end else begin
      status <= status_next;
      irq    <= |(status_next & mask);
      if (bus.wr_en && sel == ADDR_LED_OUT)  led  <= bus.wdata;
      if (bus.wr_en && sel == ADDR_IRQ_MASK) mask <= bus.wdata;
      if (bus.rd_en) bus.rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed scenarios with literal
// expectations, then randomized switch and bus traffic compared every cycle
// against a window-based behavioural model.
module tb_gpio_irq_ctrl;
  localparam int N  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] sw  = '0;
  logic [N-1:0] led;
  logic         irq;

  gpio_irq_ctrl_if #(.N_GPIO(N)) bus ();

  gpio_irq_ctrl #(.N_GPIO(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .led (led),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A level is accepted when the last DC synchronised samples (sw taken two
  // edges earlier) all disagree with the current stable value.
  logic [N-1:0] m_hist [0:DC+1];
  logic [N-1:0] m_stable, m_led, m_mask, m_status, m_rdata;
  logic         m_irq;
  logic [N-1:0] m_rise, m_clr, m_nstat, m_nstab;
  bit           m_all_diff;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j <= DC + 1; j++) m_hist[j] = '0;
      m_stable = '0; m_led = '0; m_mask = '0; m_status = '0;
      m_rdata  = '0; m_irq = 1'b0;
    end else begin
      for (int j = DC + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = sw;
      m_rise  = '0;
      m_nstab = m_stable;
      for (int i = 0; i < N; i++) begin
        m_all_diff = 1'b1;
        for (int j = 2; j <= DC + 1; j++)
          if (m_hist[j][i] == m_stable[i]) m_all_diff = 1'b0;
        if (m_all_diff) begin
          m_nstab[i] = ~m_stable[i];
          if (!m_stable[i]) m_rise[i] = 1'b1;
        end
      end
      m_clr   = (bus.wr_en && bus.addr == 2'd3) ? bus.wdata : '0;
      m_nstat = (m_status & ~m_clr) | m_rise;
      m_irq   = |(m_nstat & m_mask);
      if (bus.rd_en) begin
        case (bus.addr)
          2'd0: m_rdata = m_stable;
          2'd1: m_rdata = m_led;
          2'd2: m_rdata = m_mask;
          default: m_rdata = m_status;
        endcase
      end
      if (bus.wr_en && bus.addr == 2'd1) m_led  = bus.wdata;
      if (bus.wr_en && bus.addr == 2'd2) m_mask = bus.wdata;
      m_status = m_nstat;
      m_stable = m_nstab;
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("led",   led,       m_led);
      check("rdata", bus.rdata, m_rdata);
      check("irq",   irq,       m_irq);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.rd_en = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    tick(2);
    rst = 1'b1;
    check("reset_led",   led,       '0);
    check("reset_rdata", bus.rdata, '0);
    check("reset_irq",   irq,       1'b0);

    // 1: asynchronous reset in the middle of a debounce count
    wr(2'd1, 4'hA);
    check("t1_led_pre", led, 4'hA);
    sw = 4'hF;
    tick(3);
    #3 rst = 1'b0;
    #1;
    check("t1_async_led",   led,       '0);
    check("t1_async_rdata", bus.rdata, '0);
    check("t1_async_irq",   irq,       1'b0);
    check("t1_model_stat",  m_status,  '0);
    @(negedge clk) rst = 1'b1;
    rd(2'd0);
    check("t1_sw_in_early", bus.rdata, 4'h0);
    tick(6);
    rd(2'd0);
    check("t1_sw_in_late", bus.rdata, 4'hF);
    sw = 4'h0;
    tick(8);
    wr(2'd3, 4'hF);
    rd(2'd3);
    check("t1_status_clr", bus.rdata, 4'h0);

    // 2: glitch rejection, then a held change accepted at edge 6
    sw = 4'b0010;
    tick(3);
    sw = 4'b0000;
    tick(8);
    rd(2'd0);
    check("t2_glitch_sw", bus.rdata, 4'h0);
    rd(2'd3);
    check("t2_glitch_stat", bus.rdata, 4'h0);
    check("t2_glitch_irq", irq, 1'b0);
    sw = 4'b0010;
    tick(5);
    check("t2_model_edge5", m_stable, 4'b0000);
    tick(1);
    check("t2_model_edge6", m_stable, 4'b0010);
    check("t2_model_stat6", m_status, 4'b0010);
    rd(2'd0);
    check("t2_sw_in", bus.rdata, 4'b0010);
    rd(2'd3);
    check("t2_status", bus.rdata, 4'b0010);
    wr(2'd3, 4'b0010);

    // 3: masked interrupt and W1C
    sw = 4'b0000;
    tick(8);
    wr(2'd2, 4'b0010);
    sw = 4'b0010;
    tick(5);
    check("t3_irq_before", irq, 1'b0);
    tick(1);
    check("t3_irq_set", irq, 1'b1);
    rd(2'd3);
    check("t3_status", bus.rdata, 4'b0010);
    wr(2'd3, 4'b0010);
    check("t3_irq_clr", irq, 1'b0);
    rd(2'd3);
    check("t3_status_clr", bus.rdata, 4'b0000);

    // 4: mask gating, unmasking a pending bit
    wr(2'd2, 4'b0000);
    sw = 4'b0110;
    tick(6);
    rd(2'd3);
    check("t4_status", bus.rdata, 4'b0100);
    check("t4_irq_masked", irq, 1'b0);
    wr(2'd2, 4'b0100);
    check("t4_irq_same_edge", irq, 1'b0);
    tick(1);
    check("t4_irq_unmasked", irq, 1'b1);

    // 5: set wins over a simultaneous clear
    wr(2'd2, 4'b0101);
    sw = 4'b0111;
    tick(5);
    wr(2'd3, 4'b0001);
    check("t5_irq", irq, 1'b1);
    rd(2'd3);
    check("t5_status", bus.rdata, 4'b0101);

    // 6: LED path, ignored write, read-during-write
    wr(2'd1, 4'hA);
    check("t6_led", led, 4'hA);
    rd(2'd1);
    check("t6_rd_led", bus.rdata, 4'hA);
    wr(2'd0, 4'h5);
    check("t6_led_kept", led, 4'hA);
    rd(2'd0);
    check("t6_sw_in", bus.rdata, 4'b0111);
    rd(2'd2);
    check("t6_mask", bus.rdata, 4'b0101);
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr = 2'd1; bus.wdata = 4'h3;
    @(negedge clk);
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    check("t6_rdw_rdata", bus.rdata, 4'hA);
    check("t6_rdw_led", led, 4'h3);

    // Randomized traffic checked against the model every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) sw[i] = ~sw[i];
      bus.wr_en = ($urandom_range(0, 4) == 0);
      bus.rd_en = ($urandom_range(0, 2) == 0);
      bus.addr  = 2'($urandom_range(0, 3));
      bus.wdata = N'($urandom);
      if (cyc == 1500) begin
        #2 rst = 1'b0;
        #1;
        check("rand_async_led", led, '0);
        check("rand_async_irq", irq, 1'b0);
        @(negedge clk) rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
